// File: rtl/rr_code_arbiter_if.sv
// ============================================================================
//  Module      : rr_code_arbiter_if
//  Description : Bundle for the eight-way round-robin code arbiter.
//                master : requester side. Drives req/done and watches
//                         code/valid/timeout.
//                slave  : arbiter side.
//  Signals     : req[7:0]  request vector, where bit i is requester i
//                done      release pulse from the current owner
//                code[2:0] index of the granted requester
//                valid     code is a live grant
//                timeout   one-cycle pulse when a grant is forcibly revoked
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rr_code_arbiter_if;
   logic [7:0] req;
   logic       done;
   logic [2:0] code;
   logic       valid;
   logic       timeout;

   modport master (
      output req,
      output done,
      input  code,
      input  valid,
      input  timeout
   );

   modport slave (
      input  req,
      input  done,
      output code,
      output valid,
      output timeout
   );
endinterface

`default_nettype wire

// File: rtl/rr_code_arbiter.sv
// ============================================================================
//  Module      : rr_code_arbiter
//  Description : Eight-way round-robin arbiter. It emits the winner as a
//                3-bit code plus a valid flag, and that code feeds a 3-to-8
//                one-hot decoder. The owner keeps its grant until it pulses
//                done or drops its request. Every release leaves at least one
//                idle cycle before the next grant. All outputs are registered.
//  Ports       : clk         rising-edge clock
//                rst         synchronous, active-high reset
//                bus (slave) req/done in; code/valid/timeout out
//  Parameters  : MAX_HOLD    longest hold, in cycles, before a forced release
//                HOLD_W      width of the hold counter
//  Options     : ARB_TIMEOUT_EN. When this macro is defined, a grant that is
//                held for MAX_HOLD cycles is revoked and timeout pulses.
//                When it is undefined, timeout is tied to 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_code_arbiter #(
   parameter int MAX_HOLD = 15,
   parameter int HOLD_W   = 4
) (
   input  wire logic          clk,
   input  wire logic          rst,
   rr_code_arbiter_if.slave   bus
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   // Reject a hold limit that the counter cannot reach.
   if (MAX_HOLD < 1 || MAX_HOLD > (2 ** HOLD_W) - 1) begin : g_bad_max_hold
      $error("rr_code_arbiter: MAX_HOLD out of range for HOLD_W");
   end

   logic [0:0]  r_state;
   logic [2:0]  r_ptr;
   logic [2:0]  r_code;
   logic        r_valid;

   logic [15:0] w_dbl;
   logic [7:0]  w_rot;
   logic [2:0]  w_off;
   logic [2:0]  w_winner;
   logic        w_any;
   logic        w_user_rel;
   logic        w_limit;

   // Rotate the request vector right by ptr. After the rotation, bit 0 is
   // requester ptr. The lowest set bit is therefore the first requester met
   // when scanning upward from ptr.
   always_comb begin
      w_dbl = {bus.req, bus.req} >> r_ptr;
      w_rot = w_dbl[7:0];
      w_off = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = 3'(i);
         end
      end
      w_winner = r_ptr + w_off;
      w_any    = |bus.req;
   end

   // A normal release happens when the owner sends done or withdraws its request.
   assign w_user_rel = bus.done || !bus.req[r_code];

`ifdef ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] r_hold;
   logic              r_timeout;

   // The counter sits at 0 while idle and counts each GRANT cycle.
   // Matching MAX_HOLD-1 here means that this edge would be the
   // MAX_HOLD-th edge of ownership.
   assign w_limit = (r_hold == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold    <= '0;
         r_timeout <= 1'b0;
      end else begin
         // A normal release that lands on the limit edge does not report a timeout.
         r_timeout <= (r_state == GRANT) && !w_user_rel && w_limit;
         if (r_state == IDLE) begin
            r_hold <= '0;
         end else begin
            r_hold <= r_hold + 1'b1;
         end
      end
   end

   assign bus.timeout = r_timeout;
`else
   assign w_limit     = 1'b0;
   assign bus.timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 3'd0;
         r_code  <= 3'd0;
         r_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_code  <= w_winner;
                  r_valid <= 1'b1;
                  r_state <= GRANT;
               end
            end
            GRANT: begin
               if (w_user_rel || w_limit) begin
                  r_valid <= 1'b0;
                  r_ptr   <= r_code + 3'd1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_valid <= 1'b0;
            end
         endcase
      end
   end

   assign bus.code  = r_code;
   assign bus.valid = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_rr_code_arbiter.sv
// ============================================================================
//  Module      : tb_rr_code_arbiter
//  Description : Scoreboard bench for rr_code_arbiter. A stimulus process
//                drives req/done/rst on the falling edge. A behavioural model
//                predicts code/valid/timeout after the next rising edge and
//                queues that prediction. A monitor pops the queue just after
//                each rising edge and compares it with the DUT outputs.
//  Options     : ARB_TIMEOUT_EN enables the forced-release model
//                (MAX_HOLD=4).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_code_arbiter;

   localparam int MAXH = 4;

   typedef struct packed {
      logic [2:0] code;
      logic       valid;
      logic       timeout;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   rr_code_arbiter_if bus ();

   rr_code_arbiter #(
      .MAX_HOLD (MAXH),
      .HOLD_W   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Model state. m_owner is -1 while nobody holds the grant.
   int   m_owner = -1;
   int   m_ptr   = 0;
   int   m_held  = 0;
   int   m_code  = 0;
   bit   m_tmo   = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Predict the outputs after the coming rising edge from the inputs
   // that will be sampled on that edge.
   task automatic model(input bit r, input logic [7:0] q, input bit d);
      exp_t e;
      m_tmo = 1'b0;
      if (r) begin
         m_owner = -1;
         m_ptr   = 0;
         m_code  = 0;
         m_held  = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < 8; k++) begin
            int j;
            j = (m_ptr + k) % 8;
            if (q[j]) begin
               m_owner = j;
               m_code  = j;
               m_held  = 0;
               break;
            end
         end
      end else begin
         m_held++;
         if (d || !q[m_owner]) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
         end
`ifdef ARB_TIMEOUT_EN
         else if (m_held >= MAXH) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_tmo   = 1'b1;
         end
`endif
      end
      e.code    = 3'(m_code);
      e.valid   = (m_owner >= 0);
      e.timeout = m_tmo;
      exp_q.push_back(e);
   endtask

   task automatic step(input bit r, input logic [7:0] q, input bit d);
      @(negedge clk);
      rst      = r;
      bus.req  = q;
      bus.done = d;
      model(r, q, d);
   endtask

   // Monitor: compare after each rising edge whenever a prediction is pending.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("valid",   int'(bus.valid),   int'(e.valid));
         chk("code",    int'(bus.code),    int'(e.code));
         chk("timeout", int'(bus.timeout), int'(e.timeout));
      end
   end

   initial begin
      logic [7:0] rq;
      bit         dn;
      bus.req  = 8'h00;
      bus.done = 1'b0;

      // Reset for 2 cycles while every requester is active, then release reset.
      step(1, 8'hFF, 0);
      step(1, 8'hFF, 0);
      step(0, 8'hFF, 1);          // grant 0 (done is ignored while idle)

      // Rotation: with done held high, the grant goes to each requester in turn.
      repeat (17) step(0, 8'hFF, 1);
      step(0, 8'h00, 0);

      // A single request, a release, then a scan that starts just after it.
      step(0, 8'h20, 0);
      step(0, 8'h20, 0);
      step(0, 8'h20, 1);
      step(0, 8'hFF, 0);
      step(0, 8'hFF, 1);

      // Wrap and withdraw: move ptr to 7, then grant requester 7
      // and have it withdraw.
      step(0, 8'h40, 0);
      step(0, 8'h40, 1);
      step(0, 8'h81, 0);
      step(0, 8'h81, 0);
      step(0, 8'h01, 0);
      step(0, 8'h01, 0);
      step(0, 8'h01, 1);

      // done while idle must be ignored.
      step(0, 8'h00, 1);
      step(0, 8'h00, 1);

      // Reset in the middle of a grant to requester 3.
      step(0, 8'h08, 0);
      step(0, 8'h08, 0);
      step(1, 8'h08, 1);
      step(0, 8'hFF, 0);
      step(0, 8'hFF, 1);

      // Long hold with no done. With the macro this is a forced release;
      // without it the grant is held.
      step(0, 8'h00, 0);
      repeat (25) step(0, 8'h04, 0);
      step(0, 8'hFF, 0);
      step(0, 8'hFF, 1);

      // Random phase. Requests mostly persist, done is pulsed
      // occasionally, and rst is asserted rarely.
      rq = 8'h00;
      repeat (800) begin
         if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 3))
               0:       rq = 8'h00;
               1:       rq = 8'hFF;
               default: rq = 8'($urandom);
            endcase
         end else if ($urandom_range(0, 3) == 0) begin
            rq[$urandom_range(0, 7)] = ~rq[$urandom_range(0, 7)];
         end
         dn = ($urandom_range(0, 4) == 0);
         step(($urandom_range(0, 99) == 0), rq, dn);
      end

      // Let the monitor drain the queue, within a bounded number of cycles.
      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(posedge clk);
         #2;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
